mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer for the RV32I core. Shares one unified instruction/data memory between the fetch stage and the load/store path driven by the control unit's MemWrite and DataWidth signals. Serialises the two requesters, builds byte enables, sign/zero-extends load data and stalls the pipeline while an access is outstanding.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two requesters (fetch and load/store) and the memory.
// The slave modport is the arbiter's view; the master modport is the view of the core and memory.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_we;
   logic [2:0]  dm_width;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        dm_err;
   logic        stall;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_width, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_valid, dm_rdata, dm_valid, dm_err, stall,
      output mem_en, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_width, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_valid, dm_rdata, dm_valid, dm_err, stall,
      input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises fetch and load/store onto one memory, builds byte
// enables and lane-replicated store data, extends load data and stalls the pipeline meanwhile.
// Optional feature: define MEM_ARBITER_MISALIGN_TRAP_EN to reject misaligned data accesses
// with a dm_err pulse; otherwise they are issued with the low address bits forced aligned.
module mem_arbiter #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   localparam int unsigned CW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
   localparam logic [CW-1:0] LastCnt = CW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
   typedef enum logic [1:0] {SzWord, SzHalf, SzByte} size_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          gnt_dm_q, gnt_dm_d;
   logic          we_q, we_d;
   size_e         size_q, size_d;
   logic          uns_q, uns_d;
   logic          err_q, err_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          served_dm_q, served_dm_d;
   logic          served_if_q, served_if_d;

   size_e         req_size;
   logic [31:0]   req_addr;
   logic          misalign;
   logic          done, first;
   logic          served_dm_now, served_if_now;
   logic          pend_dm, pend_if, stall_int;
   logic [3:0]    be;
   logic [31:0]   lane_wdata;
   logic [31:0]   shifted;
   logic [31:0]   ext_rdata;

   // Decode the incoming data width and align the request address to its natural boundary.
   always_comb begin
      req_size = SzWord;
      case (bus.dm_width)
         3'b001, 3'b101: req_size = SzHalf;
         3'b010, 3'b110: req_size = SzByte;
         default:        req_size = SzWord;
      endcase
      misalign = ((req_size == SzHalf) && bus.dm_addr[0]) ||
                 ((req_size == SzWord) && (bus.dm_addr[1:0] != 2'b00));
      req_addr = bus.dm_addr;
      if (req_size == SzHalf) begin
         req_addr[0] = 1'b0;
      end else if (req_size == SzWord) begin
         req_addr[1:0] = 2'b00;
      end
   end

   // Pending/stall logic; served flags count the completion happening in this DONE cycle.
   always_comb begin
      done          = (state_q == StDone) && !rst;
      first         = (state_q == StAccess) && (cnt_q == '0) && !rst;
      served_dm_now = served_dm_q || ((state_q == StDone) && gnt_dm_q);
      served_if_now = served_if_q || ((state_q == StDone) && !gnt_dm_q);
      pend_dm       = bus.dm_req && !served_dm_now;
      pend_if       = bus.if_req && !served_if_now;
      stall_int     = pend_dm || pend_if || (state_q == StAccess);
   end

   // Next-state logic: grant in IDLE (data first), count latency in ACCESS, complete in DONE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_dm_d    = gnt_dm_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      err_d       = err_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      served_dm_d = served_dm_now;
      served_if_d = served_if_now;
      // Flags clear once the pipeline is released so the next instruction's requests count.
      if (!stall_int) begin
         served_dm_d = 1'b0;
         served_if_d = 1'b0;
      end
      case (state_q)
         StIdle: begin
            if (pend_dm) begin
               gnt_dm_d = 1'b1;
               we_d     = bus.dm_we;
               size_d   = req_size;
               uns_d    = bus.dm_width[2];
               addr_d   = req_addr;
               wdata_d  = bus.dm_wdata;
               cnt_d    = '0;
`ifdef MEM_ARBITER_MISALIGN_TRAP_EN
               err_d    = misalign;
               state_d  = misalign ? StDone : StAccess;
`else
               err_d    = 1'b0;
               state_d  = StAccess;
`endif
            end else if (pend_if) begin
               gnt_dm_d = 1'b0;
               we_d     = 1'b0;
               size_d   = SzWord;
               uns_d    = 1'b0;
               addr_d   = bus.if_addr;
               wdata_d  = '0;
               err_d    = 1'b0;
               cnt_d    = '0;
               state_d  = StAccess;
            end
         end
         StAccess: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDone: begin
            err_d   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         gnt_dm_q    <= 1'b0;
         we_q        <= 1'b0;
         size_q      <= SzWord;
         uns_q       <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         served_dm_q <= 1'b0;
         served_if_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_dm_q    <= gnt_dm_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         served_dm_q <= served_dm_d;
         served_if_q <= served_if_d;
      end
   end

   // Byte enables, lane-replicated store data and extended load data from the latched request.
   always_comb begin
      be         = 4'b1111;
      lane_wdata = wdata_q;
      shifted    = bus.mem_rdata >> {addr_q[1:0], 3'b000};
      ext_rdata  = bus.mem_rdata;
      case (size_q)
         SzHalf: begin
            be         = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_q[15:0]}};
            ext_rdata  = {{16{!uns_q && shifted[15]}}, shifted[15:0]};
         end
         SzByte: begin
            be         = 4'b0001 << addr_q[1:0];
            lane_wdata = {4{wdata_q[7:0]}};
            ext_rdata  = {{24{!uns_q && shifted[7]}}, shifted[7:0]};
         end
         default: ;
      endcase
      if (!gnt_dm_q) begin
         be = 4'b1111;
      end
   end

   // Memory strobe only in the first ACCESS cycle; everything is zero otherwise and in reset.
   assign bus.mem_en    = first;
   assign bus.mem_we    = first && gnt_dm_q && we_q;
   assign bus.mem_addr  = first ? {addr_q[31:2], 2'b00} : '0;
   assign bus.mem_be    = first ? be : '0;
   assign bus.mem_wdata = (first && gnt_dm_q && we_q) ? lane_wdata : '0;

   assign bus.if_valid  = done && !gnt_dm_q;
   assign bus.if_rdata  = (done && !gnt_dm_q) ? bus.mem_rdata : '0;
   assign bus.dm_valid  = done && gnt_dm_q && !err_q;
   assign bus.dm_rdata  = (done && gnt_dm_q && !err_q) ? ext_rdata : '0;
   assign bus.dm_err    = done && gnt_dm_q && err_q;
   assign bus.stall     = stall_int && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: one instance at latency 1, one at latency 2.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus1 ();
   mem_arbiter_if bus2 ();

   mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   mem_arbiter #(.MEM_LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   typedef struct {
      int          kind;  // 0 fetch valid, 1 data valid, 2 data error
      int          cyc;
      logic [31:0] data;
      bit          chk;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   logic        use2 = 1'b0;
   logic        m_en, m_we, m_stall, m_ifv, m_dmv, m_err;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_ifd, m_dmd;

   assign m_en    = use2 ? bus2.mem_en    : bus1.mem_en;
   assign m_we    = use2 ? bus2.mem_we    : bus1.mem_we;
   assign m_stall = use2 ? bus2.stall     : bus1.stall;
   assign m_ifv   = use2 ? bus2.if_valid  : bus1.if_valid;
   assign m_dmv   = use2 ? bus2.dm_valid  : bus1.dm_valid;
   assign m_err   = use2 ? bus2.dm_err    : bus1.dm_err;
   assign m_be    = use2 ? bus2.mem_be    : bus1.mem_be;
   assign m_addr  = use2 ? bus2.mem_addr  : bus1.mem_addr;
   assign m_wdata = use2 ? bus2.mem_wdata : bus1.mem_wdata;
   assign m_ifd   = use2 ? bus2.if_rdata  : bus1.if_rdata;
   assign m_dmd   = use2 ? bus2.dm_rdata  : bus1.dm_rdata;

   logic [15:0] en_bits, st_bits;
   logic        we_log[16];
   logic [3:0]  be_log[16];
   logic [31:0] addr_log[16], wd_log[16];

   // Load table: width, address, expected byte enables, expected extended data.
   logic [2:0]  ld_w[6]    = '{3'b010, 3'b110, 3'b001, 3'b101, 3'b000, 3'b010};
   logic [31:0] ld_a[6]    = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200, 32'h200};
   logic [3:0]  ld_be[6]   = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0001};
   logic [31:0] ld_exp[6]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                               32'h80FF1234, 32'h00000034};
   // Store table: width, address, data, expected byte enables, expected lane data.
   logic [2:0]  st_w[3]    = '{3'b001, 3'b010, 3'b000};
   logic [31:0] st_a[3]    = '{32'h206, 32'h201, 32'h300};
   logic [31:0] st_d[3]    = '{32'h0000ABCD, 32'h000000EF, 32'hDEADBEEF};
   logic [3:0]  st_be[3]   = '{4'b1100, 4'b0010, 4'b1111};
   logic [31:0] st_exp[3]  = '{32'hABCDABCD, 32'hEFEFEFEF, 32'hDEADBEEF};

   // Steps n cycles of the selected instance, logging the memory side and popping the
   // scoreboard on each completion pulse. The requester drops its requests once stall is low.
   task automatic run_cycles(input bit sel2, input int n, input int drop_at);
      exp_t        e;
      int          kind;
      logic [31:0] data;
      use2    = sel2;
      en_bits = '0;
      st_bits = '0;
      for (int c = 0; c < n; c++) begin
         if (c > 0) @(negedge clk);
         if (c == drop_at) begin
            if (sel2) begin bus2.if_req = 1'b0; bus2.dm_req = 1'b0; end
            else      begin bus1.if_req = 1'b0; bus1.dm_req = 1'b0; end
         end
         #1;
         en_bits[c]  = m_en;
         st_bits[c]  = m_stall;
         we_log[c]   = m_we;
         be_log[c]   = m_be;
         addr_log[c] = m_addr;
         wd_log[c]   = m_wdata;
         if (m_ifv || m_dmv || m_err) begin
            kind = m_err ? 2 : (m_dmv ? 1 : 0);
            data = m_dmv ? m_dmd : m_ifd;
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, none expected",
                        kind, c);
            end else begin
               e = sb.pop_front();
               if (e.kind !== kind || e.cyc !== c || (e.chk && e.data !== data)) begin
                  miscompares++;
                  $display("FAIL scoreboard: got kind %0d cyc %0d data %h, need kind %0d cyc %0d data %h",
                           kind, c, data, e.kind, e.cyc, e.data);
               end
            end
         end
         if (!m_stall) begin
            if (sel2) begin bus2.if_req = 1'b0; bus2.dm_req = 1'b0; end
            else      begin bus1.if_req = 1'b0; bus1.dm_req = 1'b0; end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_pulse: got none, need kind %0d at cycle %0d", e.kind, e.cyc);
      end
   endtask

   task automatic push(input int kind, input int cyc, input logic [31:0] data, input bit chk);
      exp_t e;
      e.kind = kind;
      e.cyc  = cyc;
      e.data = data;
      e.chk  = chk;
      sb.push_back(e);
   endtask

   task automatic test_reset;
      rst            = 1'b1;
      bus1.if_req    = 1'b1;
      bus1.if_addr   = 32'h100;
      bus1.mem_rdata = 32'h00500093;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         vectors++;
         if ({bus1.mem_en, bus1.mem_we, bus1.mem_be, bus1.mem_addr, bus1.mem_wdata,
              bus1.if_valid, bus1.if_rdata, bus1.dm_valid, bus1.dm_rdata, bus1.dm_err,
              bus1.stall} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got en=%b stall=%b be=%b ifv=%b, need all zero",
                     bus1.mem_en, bus1.stall, bus1.mem_be, bus1.if_valid);
         end
      end
      rst = 1'b0;
      push(0, 2, 32'h00500093, 1'b1);
      run_cycles(1'b0, 4, -1);
      vectors++;
      if (en_bits[3:0] !== 4'b0010) begin
         miscompares++;
         $display("FAIL reset_first_grant: got mem_en %b, need 0010", en_bits[3:0]);
      end
   endtask

   task automatic test_fetch;
      @(negedge clk);
      bus1.if_addr   = 32'h100;
      bus1.mem_rdata = 32'h00500093;
      bus1.if_req    = 1'b1;
      push(0, 2, 32'h00500093, 1'b1);
      run_cycles(1'b0, 4, -1);
      vectors++;
      if (en_bits[3:0] !== 4'b0010) begin
         miscompares++;
         $display("FAIL fetch_en: got %b, need 0010", en_bits[3:0]);
      end
      vectors++;
      if ({we_log[1], be_log[1], addr_log[1]} !== {1'b0, 4'b1111, 32'h100}) begin
         miscompares++;
         $display("FAIL fetch_bus: got we=%b be=%b addr=%h, need 0 1111 00000100",
                  we_log[1], be_log[1], addr_log[1]);
      end
      vectors++;
      if (st_bits[3:0] !== 4'b0011) begin
         miscompares++;
         $display("FAIL fetch_stall: got %b, need 0011", st_bits[3:0]);
      end
   endtask

   task automatic test_load;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus1.mem_rdata = 32'h80FF1234;
         bus1.dm_we     = 1'b0;
         bus1.dm_width  = ld_w[i];
         bus1.dm_addr   = ld_a[i];
         bus1.dm_req    = 1'b1;
         push(1, 2, ld_exp[i], 1'b1);
         run_cycles(1'b0, 4, -1);
         vectors++;
         if ({en_bits[3:0], we_log[1], be_log[1], addr_log[1]} !==
             {4'b0010, 1'b0, ld_be[i], ld_a[i] & 32'hFFFFFFFC}) begin
            miscompares++;
            $display("FAIL load_bus[%0d]: got en=%b we=%b be=%b addr=%h, need be=%b",
                     i, en_bits[3:0], we_log[1], be_log[1], addr_log[1], ld_be[i]);
         end
      end
   endtask

   task automatic test_store;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus1.dm_we    = 1'b1;
         bus1.dm_width = st_w[i];
         bus1.dm_addr  = st_a[i];
         bus1.dm_wdata = st_d[i];
         bus1.dm_req   = 1'b1;
         push(1, 2, 32'h0, 1'b0);
         run_cycles(1'b0, 4, -1);
         vectors++;
         if ({en_bits[3:0], we_log[1], be_log[1], wd_log[1], addr_log[1]} !==
             {4'b0010, 1'b1, st_be[i], st_exp[i], st_a[i] & 32'hFFFFFFFC}) begin
            miscompares++;
            $display("FAIL store_bus[%0d]: got en=%b we=%b be=%b wdata=%h, need be=%b wdata=%h",
                     i, en_bits[3:0], we_log[1], be_log[1], wd_log[1], st_be[i], st_exp[i]);
         end
      end
      bus1.dm_we = 1'b0;
   endtask

   task automatic test_dropped_request;
      @(negedge clk);
      bus1.if_addr   = 32'h40;
      bus1.mem_rdata = 32'h00A00113;
      bus1.if_req    = 1'b1;
      push(0, 2, 32'h00A00113, 1'b1);
      run_cycles(1'b0, 4, 1);
      vectors++;
      if (en_bits[3:0] !== 4'b0010) begin
         miscompares++;
         $display("FAIL dropped_en: got %b, need 0010", en_bits[3:0]);
      end
   endtask

   task automatic test_misalign;
      @(negedge clk);
      bus1.mem_rdata = 32'hCAFEF00D;
      bus1.dm_we     = 1'b0;
      bus1.dm_width  = 3'b000;
      bus1.dm_addr   = 32'h102;
      bus1.dm_req    = 1'b1;
`ifdef MEM_ARBITER_MISALIGN_TRAP_EN
      push(2, 1, 32'h0, 1'b0);
      run_cycles(1'b0, 4, -1);
      vectors++;
      if (en_bits[3:0] !== 4'b0000) begin
         miscompares++;
         $display("FAIL misalign_trap_en: got %b, need 0000", en_bits[3:0]);
      end
`else
      push(1, 2, 32'hCAFEF00D, 1'b1);
      run_cycles(1'b0, 4, -1);
      vectors++;
      if ({en_bits[3:0], be_log[1], addr_log[1]} !== {4'b0010, 4'b1111, 32'h100}) begin
         miscompares++;
         $display("FAIL misalign_word: got en=%b be=%b addr=%h, need 0010 1111 00000100",
                  en_bits[3:0], be_log[1], addr_log[1]);
      end
      @(negedge clk);
      bus1.dm_width = 3'b001;
      bus1.dm_addr  = 32'h201;
      bus1.dm_req   = 1'b1;
      push(1, 2, 32'hFFFFF00D, 1'b1);
      run_cycles(1'b0, 4, -1);
      vectors++;
      if ({en_bits[3:0], be_log[1], addr_log[1]} !== {4'b0010, 4'b0011, 32'h200}) begin
         miscompares++;
         $display("FAIL misalign_half: got en=%b be=%b addr=%h, need 0010 0011 00000200",
                  en_bits[3:0], be_log[1], addr_log[1]);
      end
`endif
   endtask

   task automatic test_concurrent;
      @(negedge clk);
      bus2.mem_rdata = 32'h12345678;
      bus2.dm_we     = 1'b0;
      bus2.dm_width  = 3'b000;
      bus2.dm_addr   = 32'h400;
      bus2.if_addr   = 32'h500;
      bus2.dm_req    = 1'b1;
      bus2.if_req    = 1'b1;
      push(1, 3, 32'h12345678, 1'b1);
      push(0, 7, 32'h12345678, 1'b1);
      run_cycles(1'b1, 9, -1);
      vectors++;
      if (en_bits[8:0] !== 9'b000100010) begin
         miscompares++;
         $display("FAIL concurrent_en: got %b, need 000100010", en_bits[8:0]);
      end
      vectors++;
      if ({addr_log[1], addr_log[5]} !== {32'h400, 32'h500}) begin
         miscompares++;
         $display("FAIL concurrent_addr: got %h %h, need 00000400 00000500",
                  addr_log[1], addr_log[5]);
      end
      vectors++;
      if (st_bits[8:0] !== 9'b001111111) begin
         miscompares++;
         $display("FAIL concurrent_stall: got %b, need 001111111", st_bits[8:0]);
      end
   endtask

   task automatic test_reset_mid_access;
      int pulses;
      @(negedge clk);
      bus2.dm_addr  = 32'h600;
      bus2.dm_width = 3'b000;
      bus2.dm_req   = 1'b1;
      run_cycles(1'b1, 2, -1);
      vectors++;
      if (en_bits[1:0] !== 2'b10) begin
         miscompares++;
         $display("FAIL midreset_en: got %b, need 10", en_bits[1:0]);
      end
      @(negedge clk);
      rst         = 1'b1;
      bus2.dm_req = 1'b0;
      #1;
      vectors++;
      if (bus2.stall !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_stall: got %b, need 0", bus2.stall);
      end
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         pulses += int'(bus2.dm_valid) + int'(bus2.if_valid) + int'(bus2.mem_en) +
                   int'(bus2.stall);
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL midreset_quiet: got %0d active samples, need 0", pulses);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus1.if_req = 1'b0;  bus1.if_addr = '0;  bus1.dm_req = 1'b0;  bus1.dm_we = 1'b0;
      bus1.dm_width = '0;  bus1.dm_addr = '0;  bus1.dm_wdata = '0;  bus1.mem_rdata = '0;
      bus2.if_req = 1'b0;  bus2.if_addr = '0;  bus2.dm_req = 1'b0;  bus2.dm_we = 1'b0;
      bus2.dm_width = '0;  bus2.dm_addr = '0;  bus2.dm_wdata = '0;  bus2.mem_rdata = '0;
      test_reset;
      test_fetch;
      test_load;
      test_store;
      test_dropped_request;
      test_misalign;
      test_concurrent;
      test_reset_mid_access;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, need finish before time limit");
      $fatal(1);
   end

endmodule
